// File: rtl/pipe_pkg.sv
// pipe_pkg: shared defaults, bubble constant and control-word field layout for pipe_stage.
package pipe_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int CTRL_W_DEF = 16;
    localparam logic [CTRL_W_DEF-1:0] CTRL_BUBBLE = '0;
    localparam int CTRL_OP_LSB  = 0;
    localparam int CTRL_OP_W    = 8;
    localparam int CTRL_RD_LSB  = 8;
    localparam int CTRL_RD_W    = 5;
    localparam int CTRL_WE_BIT  = 13;
    localparam int CTRL_MEM_BIT = 14;
    localparam int CTRL_BR_BIT  = 15;
endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: one pipeline entry (valid + pc + ctrl + data); load wins over clear, clear leaves a bubble.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int NUM_OPS = 2,
    parameter int CTRL_W  = CTRL_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load,
    input  logic                      clear,
    input  logic [31:0]               in_pc,
    input  logic [CTRL_W-1:0]         in_ctrl,
    input  logic [NUM_OPS*DATA_W-1:0] in_data,
    output logic                      valid,
    output logic [31:0]               pc,
    output logic [CTRL_W-1:0]         ctrl,
    output logic [NUM_OPS*DATA_W-1:0] data
);
    logic                      valid_d, valid_q;
    logic [31:0]               pc_d, pc_q;
    logic [CTRL_W-1:0]         ctrl_d, ctrl_q;
    logic [NUM_OPS*DATA_W-1:0] data_d, data_q;

    always_comb begin
        valid_d = load ? 1'b1 : clear ? 1'b0 : valid_q;
        pc_d    = load ? in_pc : clear ? 32'h0 : pc_q;
        ctrl_d  = load ? in_ctrl : clear ? CTRL_W'(CTRL_BUBBLE) : ctrl_q;
        data_d  = load ? in_data : data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign pc    = pc_q;
    assign ctrl  = ctrl_q;
    assign data  = data_q;
endmodule

// File: rtl/pipe_stage.sv
// pipe_stage: valid/ready pipeline register with per-slot operand forwarding and flush.
// Define PIPE_STAGE_SKID_EN to add a skid entry so in_ready no longer depends on out_ready.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int NUM_OPS = 2,
    parameter int CTRL_W  = CTRL_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [31:0]               in_pc,
    input  logic [CTRL_W-1:0]         in_ctrl,
    input  logic [NUM_OPS*DATA_W-1:0] in_data,
    input  logic [NUM_OPS-1:0]        fwd_sel,
    input  logic [NUM_OPS*DATA_W-1:0] fwd_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [31:0]               out_pc,
    output logic [CTRL_W-1:0]         out_ctrl,
    output logic [NUM_OPS*DATA_W-1:0] out_data
);
    logic                      accept, consume, main_load, main_clear;
    logic [NUM_OPS*DATA_W-1:0] cap_data;
    logic [31:0]               main_pc_src;
    logic [CTRL_W-1:0]         main_ctrl_src;
    logic [NUM_OPS*DATA_W-1:0] main_data_src;

    always_comb begin
        cap_data = in_data;
        for (int i = 0; i < NUM_OPS; i++)
            if (fwd_sel[i]) cap_data[i*DATA_W +: DATA_W] = fwd_data[i*DATA_W +: DATA_W];
    end

    assign accept     = in_valid && in_ready;
    assign consume    = out_valid && out_ready;
    assign main_clear = flush || consume;

`ifdef PIPE_STAGE_SKID_EN
    logic                      skid_valid, skid_load;
    logic [31:0]               skid_pc;
    logic [CTRL_W-1:0]         skid_ctrl;
    logic [NUM_OPS*DATA_W-1:0] skid_data;

    assign in_ready = !skid_valid;

    // A held skid beat always advances first, so order is kept across a stall.
    always_comb begin
        main_load     = !flush && (skid_valid ? consume : accept && (!out_valid || out_ready));
        skid_load     = !flush && accept && out_valid && !out_ready;
        main_pc_src   = skid_valid ? skid_pc : in_pc;
        main_ctrl_src = skid_valid ? skid_ctrl : in_ctrl;
        main_data_src = skid_valid ? skid_data : cap_data;
    end

    pipe_slot #(.DATA_W(DATA_W), .NUM_OPS(NUM_OPS), .CTRL_W(CTRL_W)) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (skid_load),
        .clear   (main_clear),
        .in_pc   (in_pc),
        .in_ctrl (in_ctrl),
        .in_data (cap_data),
        .valid   (skid_valid),
        .pc      (skid_pc),
        .ctrl    (skid_ctrl),
        .data    (skid_data)
    );
`else
    assign in_ready = !out_valid || out_ready;

    always_comb begin
        main_load     = !flush && accept;
        main_pc_src   = in_pc;
        main_ctrl_src = in_ctrl;
        main_data_src = cap_data;
    end
`endif

    pipe_slot #(.DATA_W(DATA_W), .NUM_OPS(NUM_OPS), .CTRL_W(CTRL_W)) u_main (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (main_load),
        .clear   (main_clear),
        .in_pc   (main_pc_src),
        .in_ctrl (main_ctrl_src),
        .in_data (main_data_src),
        .valid   (out_valid),
        .pc      (out_pc),
        .ctrl    (out_ctrl),
        .data    (out_data)
    );
endmodule

// File: tb/tb_pipe_stage.sv
// tb_pipe_stage: directed stimulus checked against a FIFO-occupancy model of the stage.
module tb_pipe_stage;
    localparam int DW = 32;
    localparam int N  = 2;
    localparam int CW = 16;
`ifdef PIPE_STAGE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    typedef struct packed {
        logic [31:0]     pc;
        logic [CW-1:0]   ctrl;
        logic [N*DW-1:0] data;
    } beat_t;

    logic            clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 0;
    logic            in_ready, out_valid;
    logic [31:0]     in_pc = 0, out_pc;
    logic [CW-1:0]   in_ctrl = 0, out_ctrl;
    logic [N*DW-1:0] in_data = 0, fwd_data = 0, out_data;
    logic [N-1:0]    fwd_sel = 0;
    int              checks = 0, errors = 0;
    logic            seen200 = 0;
    beat_t           q[$];

    always #5 clk = ~clk;

    pipe_stage #(.DATA_W(DW), .NUM_OPS(N), .CTRL_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_ctrl(in_ctrl), .in_data(in_data), .fwd_sel(fwd_sel),
        .fwd_data(fwd_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_ctrl(out_ctrl), .out_data(out_data)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic beat_t capture();
        beat_t b;
        b.pc   = in_pc;
        b.ctrl = in_ctrl;
        for (int i = 0; i < N; i++)
            b.data[i*DW +: DW] = fwd_sel[i] ? fwd_data[i*DW +: DW] : in_data[i*DW +: DW];
        return b;
    endfunction

    function automatic logic exp_ready();
        return (CAP == 2) ? (q.size() < 2) : (q.size() == 0 || out_ready);
    endfunction

    // Model: the stage is a FIFO of depth CAP whose head is the output.
    always @(posedge clk or negedge rst_n) begin : model
        logic acc;
        if (!rst_n) q.delete();
        else if (flush) q.delete();
        else begin
            acc = in_valid && exp_ready();
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            if (acc) q.push_back(capture());
        end
    end

    always @(negedge clk) begin
        chk("in_ready", in_ready, exp_ready());
        chk("out_valid", out_valid, q.size() > 0);
        if (q.size() > 0) begin
            chk("out_pc", out_pc, q[0].pc);
            chk("out_ctrl", out_ctrl, q[0].ctrl);
            chk("out_data", out_data, q[0].data);
        end else begin
            chk("bubble_pc", out_pc, 0);
            chk("bubble_ctrl", out_ctrl, 0);
            if (!rst_n) chk("reset_data", out_data, 0);
        end
        if (out_valid && out_pc == 32'h200) seen200 = 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic a;
        tick();
        tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        rst_n = 1;
        #1;
        chk("rst_in_ready", in_ready, 1);
        tick();

        // single beat
        in_valid = 1; in_pc = 32'h100; in_ctrl = 16'h00A5; in_data = {32'h22, 32'h11}; out_ready = 1;
        tick();
        in_valid = 0;
        chk("single_valid", out_valid, 1);
        chk("single_pc", out_pc, 32'h100);
        chk("single_ctrl", out_ctrl, 16'h00A5);
        chk("single_data", out_data, {32'h22, 32'h11});
        tick();
        chk("single_drain_valid", out_valid, 0);
        chk("single_drain_ctrl", out_ctrl, 0);

        // forwarding on slot 1 only
        in_valid = 1; in_pc = 32'h104; in_ctrl = 16'h0003; fwd_sel = 2'b10; fwd_data = {32'hDEAD, 32'hBEEF};
        tick();
        in_valid = 0; fwd_sel = 0;
        chk("fwd_data", out_data, {32'hDEAD, 32'h11});
        tick();

        // stall with a continuously offered stream
        in_valid = 1; in_pc = 32'h300; in_ctrl = 16'h0001;
        tick();
        in_pc = 32'h304; in_ctrl = 16'h0002; out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            a = in_valid && exp_ready();
            tick();
            if (a) begin in_pc = in_pc + 4; in_ctrl = in_ctrl + 1; end
            chk("stall_pc", out_pc, 32'h300);
            chk("stall_valid", out_valid, 1);
        end
        chk("stall_in_ready", in_ready, 0);
        out_ready = 1;
        tick();
        in_valid = 0;
        chk("release_order_pc", out_pc, 32'h304);
        repeat (3) tick();

        // flush with a simultaneous accept
        in_valid = 1; in_pc = 32'h400; in_ctrl = 16'h0010; out_ready = 0;
        tick();
        flush = 1; in_pc = 32'h200; in_ctrl = 16'h0020;
        tick();
        flush = 0; in_valid = 0;
        chk("flush_valid", out_valid, 0);
        chk("flush_ctrl", out_ctrl, 0);
        chk("flush_pc", out_pc, 0);
        out_ready = 1;
        repeat (2) tick();

        // back-to-back stream
        for (int i = 0; i < 8; i++) begin
            in_valid = 1; in_pc = 32'h500 + 32'(4 * i); in_ctrl = 16'(i + 1); in_data = {$urandom, $urandom};
            tick();
            chk("b2b_valid", out_valid, 1);
            chk("b2b_pc", out_pc, 32'h500 + 32'(4 * i));
        end
        in_valid = 0;
        repeat (2) tick();

        // reset in the middle of a stall
        out_ready = 0; in_valid = 1; in_pc = 32'h600; in_ctrl = 16'h0060; in_data = {32'h66, 32'h77};
        tick();
        in_valid = 0;
        tick();
        #2 rst_n = 0;
        #1;
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_pc", out_pc, 0);
        chk("rst_mid_ctrl", out_ctrl, 0);
        chk("rst_mid_data", out_data, 0);
        tick();
        rst_n = 1;
        #1;
        chk("rst_mid_in_ready", in_ready, 1);
        repeat (2) tick();

        chk("pc200_absent", seen200, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_stage.md
PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 Parameter DATA_W, default 32, width of each operand slot.
REQ-002 Parameter NUM_OPS, default 2, number of forwardable operand slots.
REQ-003 Parameter CTRL_W, default 16, width of the packed control word.
REQ-004 clk  in  1  clock; all state changes on the rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 flush  in  1  kill the stage contents; from the branch/jump resolver.
REQ-007 in_valid  in  1  upstream beat present.
REQ-008 in_ready  out  1  stage can accept a beat this cycle.
REQ-009 in_pc  in  32  instruction PC.
REQ-010 in_ctrl  in  CTRL_W  decoded control word.
REQ-011 in_data  in  NUM_OPS*DATA_W  operand payload; slot i is bits [i*DATA_W +: DATA_W].
REQ-012 fwd_sel  in  NUM_OPS  per-slot forwarding override.
REQ-013 fwd_data  in  NUM_OPS*DATA_W  forwarded operand values, same slot layout.
REQ-014 out_valid  out  1  downstream beat present.
REQ-015 out_ready  in  1  downstream consumes the beat.
REQ-016 out_pc  out  32; out_ctrl  out  CTRL_W; out_data  out  NUM_OPS*DATA_W  registered payload.

Function
REQ-017 An accept shall occur when in_valid && in_ready; a consume shall occur when out_valid && out_ready.
REQ-018 Without skid, in_ready shall equal !out_valid || out_ready (combinational); latency from accept to out_valid shall be one cycle.
REQ-019 On accept, slot i shall capture fwd_data slot i if fwd_sel[i]=1, else in_data slot i.
REQ-020 While out_valid=1 && out_ready=0, all outputs shall hold stable.
REQ-021 Simultaneous consume and accept shall replace the payload with the new beat; out_valid stays 1.
REQ-022 Consume without accept shall drive out_valid to 0 and out_ctrl and out_pc to 0.
REQ-023 Invariant: out_valid=0 implies out_ctrl=0 and out_pc=0 (bubble); out_data is don't-care.
REQ-024 On flush=1 at an edge: out_valid, out_ctrl and out_pc shall become 0; any same-cycle accept shall be discarded; flush shall dominate accept and hold.
REQ-025 A beat shall never be duplicated or reordered.

Reset
REQ-026 While rst_n=0: out_valid=0, out_pc=0, out_ctrl=0, out_data=0, and all internal entries shall be empty.
REQ-027 After reset release, in_ready shall be 1 in the first cycle.
REQ-028 Reset asserted mid-stall shall drop the held beat with no partial output.

Configuration
REQ-029 Macro PIPE_STAGE_SKID_EN, when defined, shall add one skid entry, making in_ready a register with value !skid_valid, independent of out_ready.
REQ-030 With PIPE_STAGE_SKID_EN: an accept while the main entry is stalled shall fill the skid entry; on consume, the skid entry shall move to the main entry in the same edge.
REQ-031 With PIPE_STAGE_SKID_EN: forwarding shall apply at the accept edge only; flush shall clear both entries.
REQ-032 With PIPE_STAGE_SKID_EN: an empty-stage latency of 1 shall be preserved.
REQ-033 Without PIPE_STAGE_SKID_EN, behaviour shall be exactly REQ-018.

Structure
REQ-034 Package pipe_pkg shall hold the default DATA_W and CTRL_W values, the CTRL_BUBBLE constant (all zero) and the control-word field offsets.
REQ-035 One sub-module, pipe_slot (valid + pc + ctrl + data register with load/clear), shall be instantiated once for the main entry and once more for the skid entry when enabled.

Verification
REQ-036 Single beat: pc=0x100, ctrl=0x00A5, data={0x11,0x22}, out_ready=1 -> next cycle out_valid=1 with the same values; the cycle after, out_valid=0 and ctrl=0.
REQ-037 Forwarding: fwd_sel=2'b10, fwd_data slot1=0xDEAD -> out_data slot1=0xDEAD, slot0=in_data slot0.
REQ-038 Stall: out_ready=0 for 3 cycles with in_valid=1 -> outputs stable; no-skid: in_ready=0; skid: one extra beat accepted, then in_ready=0; order preserved after release.
REQ-039 Flush with a simultaneous accept of pc=0x200 -> out_valid=0, out_ctrl=0; pc 0x200 never appears.
REQ-040 Back-to-back: 8 beats with out_ready=1 -> 8 consumes in 8 consecutive cycles with no bubbles.
REQ-041 Reset asserted during a stall -> all outputs 0 immediately; in_ready=1 after release.
